// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default flit geometry, output-port
// encoding and the position of the destination field in a flit header.
package noc_pkg;

   localparam int unsigned FLIT_W_DEF    = 32;
   localparam int unsigned BUF_DEPTH_DEF = 4;

   // Destination port field occupies flit bits [2:0]
   localparam int unsigned HDR_PORT_LSB  = 0;
   localparam int unsigned HDR_PORT_MSB  = 2;

   typedef enum logic [2:0] {
      PORT_N = 3'd0,
      PORT_S = 3'd1,
      PORT_E = 3'd2,
      PORT_W = 3'd3,
      PORT_L = 3'd4
   } port_addr_e;

endpackage

// File: rtl/flit_fifo.sv
// First-word fall-through flit FIFO. DEPTH must be a power of two, so the
// pointers wrap naturally. Pop on an empty FIFO is ignored; a push while
// full is accepted only if a pop happens in the same cycle. Storage is not
// reset -- occupancy gates the read data instead.
module flit_fifo #(
   parameter int unsigned FLIT_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_req,
   input  logic                       pop_req,
   input  logic [FLIT_W-1:0]          wr_data,
   output logic [FLIT_W-1:0]          rd_data,
   output logic                       full,
   output logic                       empty,
   output logic                       pop_ok,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push_ok;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign pop_ok  = pop_req && !empty;
   assign push_ok = push_req && (!full || pop_ok);

   // Head flit falls through; all-zeros while empty
   always_comb begin
      rd_data = '0;
      if (!empty)
         rd_data = mem[rd_ptr];
   end

   // Flit storage write (deliberately not reset)
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok && !pop_ok)
            count <= count + CNT_W'(1);
         else if (!push_ok && pop_ok)
            count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/input_credit_buffer.sv
// Router input buffer with credit-based flow control. Wraps flit_fifo and
// adds the registered credit-return pulse, destination-port decode of the
// head flit and the overflow protocol check.
// Optional: define NOC_BUF_OVERFLOW_CHECK_EN to make overflow_err_o a
// sticky flag raised when upstream pushes into a full buffer without a
// simultaneous pop. Without it the flag is tied low; the flit is dropped
// either way.
module input_credit_buffer
   import noc_pkg::*;
#(
   parameter int unsigned FLIT_W    = FLIT_W_DEF,
   parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [FLIT_W-1:0]             data_i,
   input  logic                          valid_i,
   input  logic                          granted_i,
   output logic [FLIT_W-1:0]             data_o,
   output logic [2:0]                    req_port_addr_o,
   output logic                          req_valid_o,
   output logic                          credit_en_o,
   output logic [$clog2(BUF_DEPTH):0]    count_o,
   output logic                          overflow_err_o
);

   logic       full;
   logic       empty;
   logic       pop_ok;
   port_addr_e head_port;

   flit_fifo #(
      .FLIT_W (FLIT_W),
      .DEPTH  (BUF_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_req (valid_i),
      .pop_req  (granted_i),
      .wr_data  (data_i),
      .rd_data  (data_o),
      .full     (full),
      .empty    (empty),
      .pop_ok   (pop_ok),
      .count    (count_o)
   );

   assign req_valid_o     = !empty;
   // data_o is already zero while empty, so the decoded port is too
   assign head_port       = port_addr_e'(data_o[HDR_PORT_MSB:HDR_PORT_LSB]);
   assign req_port_addr_o = head_port;

   // One credit pulse in the cycle after each accepted pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         credit_en_o <= 1'b0;
      else
         credit_en_o <= pop_ok;
   end

`ifdef NOC_BUF_OVERFLOW_CHECK_EN
   logic ovf_evt;
   assign ovf_evt = valid_i && full && !pop_ok;

   // Sticky overflow flag, cleared only by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         overflow_err_o <= 1'b0;
      else if (ovf_evt)
         overflow_err_o <= 1'b1;
   end
`else
   logic unused_full;
   assign unused_full    = full;
   assign overflow_err_o = 1'b0;
`endif

endmodule
